// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types, constants and helpers for the single-port SRAM model
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 2;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } sram_state_e;

    function automatic int lanes(input int bits, input int gran);
        return bits / gran;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_rd_pipe
// Brief    : Data+valid delay line (1 or 2 stages) with a hold-on-idle output
// Revision : 1.0 - initial release
// ============================================================================
module sram_rd_pipe #(
    parameter int BITS         = 80,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [BITS-1:0] i_data,
    output logic [BITS-1:0] o_data,
    output logic            o_valid
);

    logic [BITS-1:0] w_d_last;
    logic            w_v_last;
    logic [BITS-1:0] r_q;
    logic            r_qv;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [BITS-1:0] r_d1;
            logic            r_v1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v1 <= 1'b0;
                end else begin
                    r_v1 <= i_valid;
                end
            end

            // Intermediate data is qualified by r_v1, so it needs no reset.
            always_ff @(posedge clk) begin
                r_d1 <= i_data;
            end

            assign w_d_last = r_d1;
            assign w_v_last = r_v1;
        end else begin : g_lat1
            assign w_d_last = i_data;
            assign w_v_last = i_valid;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q  <= '0;
            r_qv <= 1'b0;
        end else begin
            r_qv <= w_v_last;
            if (w_v_last) begin
                r_q <= w_d_last;
            end
        end
    end

    assign o_data  = r_q;
    assign o_valid = r_qv;

endmodule
`default_nettype wire

// File: rtl/sram_sp_bwe_init.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp_bwe_init
// Brief    : Single-port SRAM model, lane write mask, zero-init, 1/2-cycle read
// Revision : 1.0 - initial release
// ============================================================================
module sram_sp_bwe_init
    import sram_pkg::*;
#(
    parameter int Bits         = 80,
    parameter int Word_Depth   = 64,
    parameter int Add_Width    = 6,
    parameter int Mask_Gran    = 8,
    parameter int Read_Latency = 1,
    parameter int Init_En      = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 CEB,
    input  logic                                 WEB,
    input  logic [Add_Width-1:0]                 A,
    input  logic [Bits-1:0]                      D,
    input  logic [lanes(Bits, Mask_Gran)-1:0]    BWEB,
    output logic [Bits-1:0]                      Q,
    output logic                                 QV,
    output logic                                 READY
);

    localparam int                   c_LANES = lanes(Bits, Mask_Gran);
    localparam logic [Add_Width:0]   c_DEPTH = (Add_Width + 1)'(Word_Depth);
    localparam logic [Add_Width-1:0] c_LAST  = Add_Width'(Word_Depth - 1);

    generate
        if ((Bits % Mask_Gran) != 0) begin : g_chk_gran
            $error("sram_sp_bwe_init: Bits must be a multiple of Mask_Gran");
        end
        if ((1 << Add_Width) < Word_Depth) begin : g_chk_addr
            $error("sram_sp_bwe_init: Add_Width too small for Word_Depth");
        end
        if ((Read_Latency != c_RD_LAT_MIN) && (Read_Latency != c_RD_LAT_MAX)) begin : g_chk_lat
            $error("sram_sp_bwe_init: Read_Latency must be 1 or 2");
        end
    endgenerate

    sram_state_e          r_state;
    logic [Add_Width-1:0] r_ctr;
    logic                 r_ready;
    logic [Bits-1:0]      r_mem [Word_Depth];

    logic                 w_in_range;
    logic                 w_init_wr;
    logic                 w_host_wr;
    logic                 w_host_rd;
    logic [Bits-1:0]      w_rd_data;

    assign w_in_range = ({1'b0, A} < c_DEPTH);
    assign w_init_wr  = !RST && (r_state == INIT);
    assign w_host_wr  = !RST && r_ready && !CEB && !WEB && w_in_range;
    assign w_host_rd  = r_ready && !CEB && WEB;
    assign w_rd_data  = w_in_range ? r_mem[A] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= (Init_En != 0) ? INIT : IDLE;
            r_ctr   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_ctr <= r_ctr + Add_Width'(1);
                    // READY rises together with the last init write.
                    if (r_ctr == c_LAST) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_init_wr) begin
            r_mem[r_ctr] <= '0;
        end else if (w_host_wr) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (!BWEB[i]) begin
                    r_mem[A][i*Mask_Gran +: Mask_Gran] <= D[i*Mask_Gran +: Mask_Gran];
                end
            end
        end
    end

    sram_rd_pipe #(
        .BITS         (Bits),
        .READ_LATENCY (Read_Latency)
    ) u_rd_pipe (
        .clk     (CLK),
        .rst     (RST),
        .i_valid (w_host_rd),
        .i_data  (w_rd_data),
        .o_data  (Q),
        .o_valid (QV)
    );

    assign READY = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_bwe_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_sp_bwe_init
// Brief    : Self-checking bench: three SRAM geometries vs. a time-scheduled model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_sp_bwe_init;

    localparam int c_DEPTH [3] = '{64, 48, 64};
    localparam int c_LAT   [3] = '{1, 2, 1};
    localparam int c_INIT  [3] = '{1, 1, 0};

    typedef struct {
        logic        ceb;
        logic        web;
        logic [5:0]  a;
        logic [79:0] d;
        logic [9:0]  bweb;
        logic        exp_qv;
        logic [79:0] exp_q;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, ceb, web;
    logic [5:0]  a;
    logic [79:0] d;
    logic [9:0]  bweb;
    logic [79:0] q1, q2, q3;
    logic        qv1, qv2, qv3, rdy1, rdy2, rdy3;

    always #5 clk = ~clk;

    sram_sp_bwe_init #(.Bits(80), .Word_Depth(64), .Add_Width(6), .Mask_Gran(8),
                       .Read_Latency(1), .Init_En(1)) u_dut1 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
        .Q(q1), .QV(qv1), .READY(rdy1));

    sram_sp_bwe_init #(.Bits(80), .Word_Depth(48), .Add_Width(6), .Mask_Gran(8),
                       .Read_Latency(2), .Init_En(1)) u_dut2 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
        .Q(q2), .QV(qv2), .READY(rdy2));

    sram_sp_bwe_init #(.Bits(80), .Word_Depth(64), .Add_Width(6), .Mask_Gran(8),
                       .Read_Latency(1), .Init_En(0)) u_dut3 (
        .CLK(clk), .RST(rst), .CEB(ceb), .WEB(web), .A(a), .D(d), .BWEB(bweb),
        .Q(q3), .QV(qv3), .READY(rdy3));

    // Reference model: reads are scheduled into a time slot, READY counts edges since reset.
    logic [79:0] m_mem [3][64];
    bit          m_ready [3];
    int          m_cnt [3];
    logic [79:0] m_q [3];
    bit          m_qv [3];
    bit          s_v [3][4];
    logic [79:0] s_d [3][4];
    int          cyc;
    int          n_pass;
    int          n_total;
    vec_t        tbl [12];

    task automatic model_edge();
        cyc++;
        for (int k = 0; k < 3; k++) begin
            bit was_ready;
            int due;
            if (rst) begin
                m_cnt[k]   = 0;
                m_ready[k] = 0;
                m_q[k]     = '0;
                m_qv[k]    = 0;
                for (int s = 0; s < 4; s++) s_v[k][s] = 0;
                continue;
            end
            was_ready = m_ready[k];
            if (was_ready && !ceb && !web && (int'(a) < c_DEPTH[k])) begin
                for (int i = 0; i < 10; i++)
                    if (!bweb[i]) m_mem[k][a][i*8 +: 8] = d[i*8 +: 8];
            end
            if (was_ready && !ceb && web) begin
                due = cyc + c_LAT[k] - 1;
                s_v[k][due % 4] = 1;
                s_d[k][due % 4] = (int'(a) < c_DEPTH[k]) ? m_mem[k][a] : '0;
            end
            m_qv[k] = s_v[k][cyc % 4];
            if (s_v[k][cyc % 4]) begin
                m_q[k] = s_d[k][cyc % 4];
                s_v[k][cyc % 4] = 0;
            end
            m_cnt[k]++;
            m_ready[k] = (c_INIT[k] != 0) ? (m_cnt[k] >= c_DEPTH[k]) : (m_cnt[k] >= 1);
            if ((c_INIT[k] != 0) && m_ready[k] && !was_ready)
                for (int w = 0; w < 64; w++) m_mem[k][w] = '0;
        end
    endtask

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input bit r, input bit ce, input bit we, input logic [5:0] ad,
                        input logic [79:0] dd, input logic [9:0] be);
        rst = r; ceb = ce; web = we; a = ad; d = dd; bweb = be;
        @(posedge clk);
        model_edge();
        #1;
        check("u1 model", {rdy1, qv1, q1}, {m_ready[0], m_qv[0], m_q[0]});
        check("u2 model", {rdy2, qv2, q2}, {m_ready[1], m_qv[1], m_q[1]});
        check("u3 model", {80'b0, rdy3, qv3}, {80'b0, m_ready[2], m_qv[2]});
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b1, 6'd0, 80'd0, '1);
    endtask

    task automatic wr(input logic [5:0] ad, input logic [79:0] dd, input logic [9:0] be);
        step(1'b0, 1'b0, 1'b0, ad, dd, be);
    endtask

    task automatic rd(input logic [5:0] ad);
        logic [95:0] junk;
        junk = {$urandom(), $urandom(), $urandom()};
        step(1'b0, 1'b0, 1'b1, ad, junk[79:0], junk[89:80]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        rst = 1'b1; ceb = 1'b1; web = 1'b1; a = '0; d = '0; bweb = '1;

        step(1'b1, 1'b1, 1'b1, 6'd0, 80'd0, '1);
        check("reset u1", {rdy1, qv1, q1}, 82'h0);
        check("reset u2", {rdy2, qv2, q2}, 82'h0);
        check("reset u3", {rdy3, qv3, q3}, 82'h0);

        // Partial init with a host write that must be ignored, then reset at ctr=20.
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) wr(6'd3, '1, '0);
            else idle();
            if (k == 1) check("u3 ready 1 cycle after reset", {81'b0, rdy3}, 82'd1);
        end
        check("u1 not ready mid-init", {81'b0, rdy1}, 82'd0);
        step(1'b1, 1'b1, 1'b1, 6'd0, 80'd0, '1);
        check("u1 ready after reinit reset", {81'b0, rdy1}, 82'd0);

        for (int k = 1; k <= 70; k++) begin
            if (k == 10) wr(6'd0, '1, '0);
            else if (k == 63) wr(6'd31, '1, '0);
            else idle();
            if (k == 47) check("u2 ready @47", {81'b0, rdy2}, 82'd0);
            if (k == 48) check("u2 ready @48", {81'b0, rdy2}, 82'd1);
            if (k == 63) check("u1 ready @63", {81'b0, rdy1}, 82'd0);
            if (k == 64) check("u1 ready @64", {81'b0, rdy1}, 82'd1);
        end

        rd(6'd0);  check("init rd 0",  {rdy1, qv1, q1}, {1'b1, 1'b1, 80'h0});
        rd(6'd3);  check("init rd 3",  {rdy1, qv1, q1}, {1'b1, 1'b1, 80'h0});
        rd(6'd31); check("init rd 31", {rdy1, qv1, q1}, {1'b1, 1'b1, 80'h0});
        rd(6'd63); check("init rd 63", {rdy1, qv1, q1}, {1'b1, 1'b1, 80'h0});

        tbl[0]  = '{1'b0, 1'b0, 6'd5, {80{1'b1}}, 10'h3FE, 1'b0, 80'h0};
        tbl[1]  = '{1'b0, 1'b1, 6'd5, 80'h0,      10'h3FF, 1'b1, 80'hFF};
        tbl[2]  = '{1'b1, 1'b1, 6'd5, 80'h0,      10'h3FF, 1'b0, 80'hFF};
        tbl[3]  = '{1'b0, 1'b0, 6'd7, 80'h1234,   10'h000, 1'b0, 80'hFF};
        tbl[4]  = '{1'b0, 1'b1, 6'd7, 80'h0,      10'h3FF, 1'b1, 80'h1234};
        tbl[5]  = '{1'b1, 1'b1, 6'd0, 80'h0,      10'h3FF, 1'b0, 80'h1234};
        tbl[6]  = '{1'b1, 1'b0, 6'd7, {80{1'b1}}, 10'h000, 1'b0, 80'h1234};
        tbl[7]  = '{1'b0, 1'b1, 6'd7, {80{1'b1}}, 10'h000, 1'b1, 80'h1234};
        tbl[8]  = '{1'b0, 1'b1, 6'd5, 80'h0,      10'h3FF, 1'b1, 80'hFF};
        tbl[9]  = '{1'b0, 1'b0, 6'd5, {80{1'b1}}, 10'h3FD, 1'b0, 80'hFF};
        tbl[10] = '{1'b0, 1'b1, 6'd5, 80'h0,      10'h3FF, 1'b1, 80'hFFFF};
        tbl[11] = '{1'b0, 1'b1, 6'd7, 80'h0,      10'h3FF, 1'b1, 80'h1234};
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].ceb, tbl[i].web, tbl[i].a, tbl[i].d, tbl[i].bweb);
            check($sformatf("vec %0d u1", i), {rdy1, qv1, q1}, {1'b1, tbl[i].exp_qv, tbl[i].exp_q});
        end
        idle(); idle(); idle();

        // Out-of-range access on the 48-word instance.
        wr(6'd50, 80'hAB, '0);
        rd(6'd50); check("u2 oor rd t+1", {rdy2, qv2, q2}, {1'b1, 1'b0, 80'h1234});
        idle();    check("u2 oor rd t+2", {rdy2, qv2, q2}, {1'b1, 1'b1, 80'h0});
        rd(6'd2);  check("u2 word2 t+1",  {rdy2, qv2, q2}, {1'b1, 1'b0, 80'h0});
        idle();    check("u2 word2 t+2",  {rdy2, qv2, q2}, {1'b1, 1'b1, 80'h0});

        // Back-to-back reads through the 2-stage pipe.
        wr(6'd1, 80'h11, '0);
        wr(6'd2, 80'h22, '0);
        wr(6'd3, 80'h33, '0);
        rd(6'd1); check("u2 b2b t+1", {rdy2, qv2, q2}, {1'b1, 1'b0, 80'h0});
        rd(6'd2); check("u2 b2b t+2", {rdy2, qv2, q2}, {1'b1, 1'b1, 80'h11});
        rd(6'd3); check("u2 b2b t+3", {rdy2, qv2, q2}, {1'b1, 1'b1, 80'h22});
        idle();   check("u2 b2b t+4", {rdy2, qv2, q2}, {1'b1, 1'b1, 80'h33});
        idle();   check("u2 hold 1",  {rdy2, qv2, q2}, {1'b1, 1'b0, 80'h33});
        idle();   check("u2 hold 2",  {rdy2, qv2, q2}, {1'b1, 1'b0, 80'h33});

        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [95:0] rv;
            sel = $urandom_range(0, 99);
            rv  = {$urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 299) == 0)
                step(1'b1, 1'b1, 1'b1, 6'd0, 80'd0, '1);
            else if (sel < 35)
                rd(6'($urandom_range(0, 63)));
            else if (sel < 70)
                wr(6'($urandom_range(0, 63)), rv[79:0], rv[89:80]);
            else
                step(1'b0, 1'b1, rv[90], 6'($urandom_range(0, 63)), rv[79:0], rv[89:80]);
        end
        idle(); idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
